// File: rtl/cla_slice_sequencer.sv
// Multi-cycle WIDTH-bit add/subtract that time-shares one external SLICE-bit CLA,
// feeding it one slice per cycle LSB first and chaining carry through a register.
module cla_slice_sequencer #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SLICE = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry_out,
   output logic             overflow,
   output logic [SLICE-1:0] cla_x,
   output logic [SLICE-1:0] cla_y,
   output logic             cla_cin,
   input  logic [SLICE-1:0] cla_s,
   input  logic             cla_cout
);

   localparam int unsigned NSLICE = WIDTH / SLICE;
   localparam int unsigned KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state;
   logic [KW-1:0]    k;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             carry;

   // Operands shift right one slice per RUN cycle, so the low slice is always the
   // one being added and both registers have drained to zero by the time RUN ends.
   assign cla_x   = a_sh[SLICE-1:0];
   assign cla_y   = b_sh[SLICE-1:0];
   assign cla_cin = carry;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state     <= IDLE;
         k         <= '0;
         a_sh      <= '0;
         b_sh      <= '0;
         carry     <= 1'b0;
         result    <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  a_sh     <= op_a;
                  b_sh     <= sub ? ~op_b : op_b;
                  carry    <= sub;
                  k        <= '0;
                  result   <= '0;
                  in_ready <= 1'b0;
                  state    <= RUN;
               end
            end

            RUN: begin
               result[SLICE*32'(k) +: SLICE] <= cla_s;
               carry <= cla_cout;
               a_sh  <= a_sh >> SLICE;
               b_sh  <= b_sh >> SLICE;
               k     <= k + KW'(1);
               if (k == K_LAST) begin
                  // Low slice now holds the operand MSBs for the signed-overflow test.
                  carry_out <= cla_cout;
                  overflow  <= (a_sh[SLICE-1] == b_sh[SLICE-1]) &&
                               (cla_s[SLICE-1] != a_sh[SLICE-1]);
                  carry     <= 1'b0;
                  k         <= '0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end

            default: begin
               state     <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
